// File: rtl/job_arbiter_if.sv
// job_arbiter_if: requester-side and engine-side signals of job_arbiter.
// slave is the arbiter's view; master is the view of whoever drives
// requests and models the engine.
interface job_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] cancel;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic [N-1:0] abrt;
  logic         busy;
  logic         eng_go;
  logic         eng_kill;
  logic         eng_done;
  logic         tmo;

  modport slave (
    input  req, cancel, eng_done,
    output gnt, ack, abrt, busy, eng_go, eng_kill, tmo
  );

  modport master (
    output req, cancel, eng_done,
    input  gnt, ack, abrt, busy, eng_go, eng_kill, tmo
  );
endinterface

// File: rtl/job_arbiter.sv
// job_arbiter: shares one go/kill/done job engine between N requesters.
// Requesters are granted round-robin. A grant sends one eng_go pulse and then
// waits for eng_done. The owner's cancel aborts the job through a timed
// eng_kill sequence. Each outcome is reported as a one-cycle ack or abrt pulse.
// Optional feature: define JOB_TIMEOUT_EN to abort jobs that stay BUSY for
// TIMEOUT cycles (tmo pulses when that abort starts); otherwise tmo is 0.
module job_arbiter #(
  parameter int N           = 4,
  parameter int KILL_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input logic          clk,
  input logic          reset,
  job_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    BUSY    = 3'd2,
    KILL    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d;
  logic [PW-1:0] owner, owner_d;
  logic [3:0]    kcnt, kcnt_d;
  logic [N-1:0]  gnt, gnt_d;
  logic [N-1:0]  ack, ack_d;
  logic [N-1:0]  abrt, abrt_d;
  logic          busy, busy_d;
  logic          go, go_d;
  logic          kill, kill_d;
  logic          cancel_now;
  logic          tmo_hit;
  logic          pick_found;
  logic [PW-1:0] pick;

  assign cancel_now = |(bus.cancel & gnt);

  assign bus.gnt      = gnt;
  assign bus.ack      = ack;
  assign bus.abrt     = abrt;
  assign bus.busy     = busy;
  assign bus.eng_go   = go;
  assign bus.eng_kill = kill;

`ifdef JOB_TIMEOUT_EN
  logic [7:0] tcnt, tcnt_d;
  logic       tmo, tmo_d;

  assign tmo_hit = (tcnt == 8'(TIMEOUT - 1));
  assign bus.tmo = tmo;

  // Timeout counter: cleared on the way into BUSY, counts every BUSY cycle.
  always_comb begin
    tcnt_d = tcnt;
    tmo_d  = 1'b0;
    if (state == ISSUE) begin
      tcnt_d = '0;
    end else if (state == BUSY) begin
      tcnt_d = tcnt + 8'd1;
      tmo_d  = tmo_hit && !bus.eng_done;
    end
  end

  // Timeout counter and tmo pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      tcnt <= tcnt_d;
      tmo  <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus.tmo = 1'b0;
`endif

  // Round-robin pick: first requesting bit at or above ptr, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_found && bus.req[(int'(ptr) + i) % N]) begin
        pick_found = 1'b1;
        pick       = PW'((int'(ptr) + i) % N);
      end
    end
  end

  // Next state and next registered outputs; done beats cancel and timeout.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    kcnt_d  = kcnt;
    gnt_d   = gnt;
    ack_d   = '0;
    abrt_d  = '0;
    go_d    = 1'b0;
    kill_d  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          go_d        = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.eng_done) begin
          ack_d   = gnt;
          state_d = RELEASE;
        end else if (cancel_now || tmo_hit) begin
          kill_d  = 1'b1;
          kcnt_d  = 4'd1;
          state_d = KILL;
        end
      end
      KILL: begin
        if (kcnt == 4'(KILL_CYCLES)) begin
          abrt_d  = gnt;
          kcnt_d  = '0;
          state_d = RELEASE;
        end else begin
          kill_d = 1'b1;
          kcnt_d = kcnt + 4'd1;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        kcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any job without a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      kcnt  <= '0;
      gnt   <= '0;
      ack   <= '0;
      abrt  <= '0;
      busy  <= 1'b0;
      go    <= 1'b0;
      kill  <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
      kcnt  <= kcnt_d;
      gnt   <= gnt_d;
      ack   <= ack_d;
      abrt  <= abrt_d;
      busy  <= busy_d;
      go    <= go_d;
      kill  <= kill_d;
    end
  end

endmodule

// File: doc/job_arbiter.md
Name: job_arbiter

Overview:
- Shares one go/kill/done job engine between N requesters.
- Picks a requester round-robin, sends the engine a one-cycle go pulse, then waits for done.
- Aborts the job with kill when the owner cancels it or (optionally) when it runs too long.
- Reports each job's outcome to its owner as a one-cycle ack or abrt pulse.

Parameters:
- N, 4, number of requesters (2..8).
- KILL_CYCLES, 2, number of cycles eng_kill is held high during an abort (1..15).
- TIMEOUT, 64, number of BUSY cycles before a forced abort (used only with JOB_TIMEOUT_EN; 1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  level request, one bit per requester; sampled only in IDLE.
- cancel  input  N  owner abort request; honoured only for the current owner in BUSY.
- gnt  output  N  one-hot owner of the engine; all zero when nobody owns it.
- ack  output  N  one-cycle pulse to the owner when its job completes normally.
- abrt  output  N  one-cycle pulse to the owner when its job is aborted.
- busy  output  1  high in every state except IDLE.
- eng_go  output  1  job start pulse to the engine.
- eng_kill  output  1  abort level to the engine.
- eng_done  input  1  engine completion pulse.
- tmo  output  1  one-cycle pulse when a timeout abort starts (only with JOB_TIMEOUT_EN).

Behaviour:
- Timing: all outputs are registered, and all state changes happen on the rising edge of clk.
- Reset: reset low clears every output to 0 immediately, with no clock needed.
  - State goes to IDLE.
  - Round-robin pointer goes to 0, so requester 0 has top priority after reset.
  - Kill counter goes to 0; timeout counter (if built) goes to 0.
  - Reset mid-job drops the job silently: no ack or abrt pulse. The engine is reset by the same net.
- States are IDLE, ISSUE, BUSY, KILL, RELEASE (3-bit encoding; unused codes return to IDLE).
- IDLE:
  - If req is non-zero, select the first set bit searching from ptr upward, wrapping past N-1 to 0.
  - Register gnt one-hot for that requester and move to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: eng_go = 1 for exactly this one cycle, then move to BUSY; gnt stays held.
- BUSY:
  - eng_done = 1: pulse ack[owner] on the next cycle, then move to RELEASE.
  - Otherwise, if cancel[owner] = 1 (or timeout expired): move to KILL.
  - eng_done and cancel in the same cycle: done wins; ack is sent and no abort happens.
  - cancel on a non-owner bit is ignored.
  - The owner dropping req mid-job has no effect; the job runs to the end.
- KILL:
  - eng_kill = 1 for exactly KILL_CYCLES cycles.
  - eng_kill then drops to 0, abrt[owner] pulses on that same cycle, and the state moves to RELEASE.
  - eng_done arriving during KILL is ignored.
- RELEASE (1 cycle):
  - gnt clears to 0; ptr becomes owner+1 mod N.
  - This gives the engine a cycle to pass from finish or abort back to idle.
  - Next state is IDLE.
- Spacing: the minimum gap between two eng_go pulses is the job length + 3 cycles. At most one eng_go is issued per grant.
- Fairness: a requester holding req is served within N grants.
- Pulse uniqueness: ack and abrt are one-hot, mutually exclusive, and each fires exactly once per grant.
- busy = 1 from ISSUE through RELEASE inclusive.

Optional Feature:
- Macro JOB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without eng_done, the block pulses tmo for one cycle and enters KILL exactly as for a cancel.
  - eng_done in the same cycle the count hits TIMEOUT still wins.
- Undefined: no counter is built, tmo is tied to 0, and jobs only end by eng_done or cancel.

Test Plan:
- Reset, then req=4'b0001 -> gnt=0001 one cycle later, eng_go pulses once; engine done -> ack[0] pulse, gnt=0000 one cycle after ack, busy=0.
- req=4'b1111 held for 4 jobs -> grant order 0,1,2,3, then 0 again; eng_go pulses are never closer than 4 cycles apart.
- req[2] granted, cancel[2]=1 in BUSY, KILL_CYCLES=2 -> eng_kill high exactly 2 cycles, abrt[2] pulse, no ack[2], engine idle before the next eng_go.
- eng_done and cancel[owner] asserted in the same cycle -> ack[owner] pulses, eng_kill stays 0; cancel on a non-owner bit -> no effect.
- JOB_TIMEOUT_EN with TIMEOUT=8 and an engine that never sends done -> tmo pulse after 8 BUSY cycles, then kill sequence and abrt[owner]; without the macro, tmo stays 0 and the arbiter waits indefinitely.
- reset low mid-BUSY and mid-KILL -> gnt, eng_go, eng_kill, busy all 0 immediately; after release, requester 0 has top priority and no stale ack or abrt appears.
